lut_multiplier_seq: RTL and testbench
=====================================

LUT_MULTIPLIER_SEQ -- requirements
Module: lut_multiplier_seq

Interface
REQ-001 SHALL have parameter WIDTH_A, default 32, multiplicand width.
REQ-002 SHALL have parameter WIDTH_B, default 32, multiplier width; even, >= 2.
REQ-003 SHALL have port clk_seq  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port reset_seq  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid_seq  input  1  operands valid.
REQ-006 SHALL have port in_ready_seq  output  1  block can accept operands.
REQ-007 SHALL have port source_a_seq  input  WIDTH_A  unsigned multiplicand.
REQ-008 SHALL have port source_b_seq  input  WIDTH_B  unsigned multiplier.
REQ-009 SHALL have port out_valid_seq  output  1  result valid.
REQ-010 SHALL have port out_ready_seq  input  1  consumer takes result.
REQ-011 SHALL have port result_seq  output  WIDTH_A+WIDTH_B  unsigned product.
REQ-012 SHALL have port busy_seq  output  1  high while in BUSY.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE; one state active at a time.
REQ-014 IDLE: in_ready_seq=1; in_valid_seq=1 at an edge captures A, B, clears accumulator and step counter, goes to BUSY.
REQ-015 BUSY: each edge adds the 2-bit partial product of B's two low bits (0, A, 2A, 3A) shifted left by 2*step into the accumulator, shifts B right by 2, increments step.
REQ-016 Partial-product adder SHALL be WIDTH_A+2 bits wide; accumulator WIDTH_A+WIDTH_B bits; no overflow is possible or flagged.
REQ-017 BUSY SHALL last K=WIDTH_B/2 edges, then go to DONE with result_seq loaded (except as REQ-025 allows).
REQ-018 out_valid_seq rises exactly K edges after the accepting edge (16 for defaults).
REQ-019 DONE: out_valid_seq=1, result_seq stable; out_ready_seq=1 at an edge returns to IDLE.
REQ-020 in_ready_seq=0 in BUSY and DONE; in_valid_seq there is ignored, including in the DONE-exit cycle (no same-edge reaccept).
REQ-021 result_seq SHALL hold the last product after DONE until the next product is loaded.

Reset
REQ-022 reset_seq=1 SHALL immediately force IDLE, result_seq=0, out_valid_seq=0, busy_seq=0, in_ready_seq=1, accumulator/counter=0.
REQ-023 Reset mid-BUSY or mid-DONE SHALL discard the operation; no out_valid_seq follows.

Configuration
REQ-024 Macro LUT_MULTIPLIER_SEQ_EARLY_TERM_EN selects early termination.
REQ-025 Defined: BUSY SHALL go to DONE at the edge where the shifted remaining multiplier is zero, minimum one BUSY edge; B=0 gives latency 1; with B = 0x0000_0003, latency 1; with B = 0x0000_0100, latency 5.
REQ-026 Undefined: latency SHALL always be K; results identical in both builds.

Structure
REQ-027 Package lut_multiplier_seq_pkg SHALL hold the state typedef (IDLE, BUSY, DONE) and the partial-product select constants.
REQ-028 One sub-module lut_pp_2b (combinational: WIDTH_A operand, 2-bit selector -> WIDTH_A+2 partial product) SHALL be instantiated once.

Verification
REQ-029 A=0x0000_0007, B=0x0000_0006, out_ready=1 -> result 0x2A; out_valid 16 edges after accept (no macro).
REQ-030 A=B=0xFFFF_FFFF -> result 0xFFFF_FFFE_0000_0001.
REQ-031 A=0x1234_5678, B=0 -> result 0; latency 16 without macro, 1 with macro.
REQ-032 Hold out_ready=0 for 5 cycles in DONE, pulse in_valid with new operands -> result stable, no accept; accept only after return to IDLE.
REQ-033 Assert reset_seq at BUSY step 8 -> outputs at reset values immediately; next operation A=3, B=5 -> 15.
REQ-034 10000 random operand pairs, random out_ready backpressure -> all products match reference model; params WIDTH_A=8, WIDTH_B=4 also run.

Source files
------------

// File: rtl/lut_multiplier_seq_pkg.sv
// lut_multiplier_seq_pkg: shared FSM state type and 2-bit partial-product select codes.
package lut_multiplier_seq_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [1:0] PP_ZERO = 2'd0;
  localparam logic [1:0] PP_X1   = 2'd1;
  localparam logic [1:0] PP_X2   = 2'd2;
  localparam logic [1:0] PP_X3   = 2'd3;
endpackage

// File: rtl/lut_multiplier_seq_pp.sv
// lut_pp_2b: combinational radix-4 lookup selecting 0, A, 2A or 3A from a 2-bit multiplier digit.
module lut_pp_2b
  import lut_multiplier_seq_pkg::*;
#(
  parameter int WIDTH_A = 32
) (
  input  logic [WIDTH_A-1:0] a,
  input  logic [1:0]         sel,
  output logic [WIDTH_A+1:0] pp
);
  logic [WIDTH_A+1:0] a1, a2;
  always_comb begin
    a1 = {2'b00, a};
    a2 = {1'b0, a, 1'b0};
    pp = sel == PP_ZERO ? '0 : sel == PP_X1 ? a1 : sel == PP_X2 ? a2 : a1 + a2;
  end
endmodule

// File: rtl/lut_multiplier_seq.sv
// lut_multiplier_seq: sequential radix-4 unsigned multiplier with valid/ready handshakes.
// LUT_MULTIPLIER_SEQ_EARLY_TERM_EN finishes as soon as the remaining multiplier digits are all zero.
module lut_multiplier_seq
  import lut_multiplier_seq_pkg::*;
#(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 32
) (
  input  logic                       clk_seq,
  input  logic                       reset_seq,
  input  logic                       in_valid_seq,
  output logic                       in_ready_seq,
  input  logic [WIDTH_A-1:0]         source_a_seq,
  input  logic [WIDTH_B-1:0]         source_b_seq,
  output logic                       out_valid_seq,
  input  logic                       out_ready_seq,
  output logic [WIDTH_A+WIDTH_B-1:0] result_seq,
  output logic                       busy_seq
);
  localparam int K  = WIDTH_B / 2;
  localparam int SW = $clog2(K + 1);
  localparam int RW = WIDTH_A + WIDTH_B;
  state_t              state_q, state_d;
  logic [WIDTH_A-1:0]  a_q, a_d;
  logic [WIDTH_B-1:0]  b_q, b_d;
  logic [RW-1:0]       acc_q, acc_d, result_q, result_d, pp_ext;
  logic [SW-1:0]       step_q, step_d;
  logic [WIDTH_A+1:0]  pp;
  logic                last_step;
  lut_pp_2b #(.WIDTH_A(WIDTH_A)) u_pp (
    .a   (a_q),
    .sel (b_q[1:0]),
    .pp  (pp)
  );
  always_comb begin
`ifdef LUT_MULTIPLIER_SEQ_EARLY_TERM_EN
    last_step = (b_q >> 2) == '0;
`else
    last_step = step_q == SW'(K - 1);
`endif
    pp_ext   = RW'(pp) << {step_q, 1'b0};
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    step_d   = step_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (in_valid_seq) begin
        a_d     = source_a_seq;
        b_d     = source_b_seq;
        acc_d   = '0;
        step_d  = '0;
        state_d = BUSY;
      end
      BUSY: begin
        acc_d  = acc_q + pp_ext;
        b_d    = b_q >> 2;
        step_d = step_q + SW'(1);
        if (last_step) begin
          state_d  = DONE;
          result_d = acc_d;
        end
      end
      DONE: if (out_ready_seq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_seq or posedge reset_seq) begin
    if (reset_seq) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      result_q <= result_d;
    end
  end
  assign in_ready_seq  = state_q == IDLE;
  assign busy_seq      = state_q == BUSY;
  assign out_valid_seq = state_q == DONE;
  assign result_seq    = result_q;
endmodule

// File: tb/tb_lut_multiplier_seq.sv
// tb_lut_multiplier_seq: scoreboard bench for the 32x32 default build plus an 8x4 instance.
module tb_lut_multiplier_seq;
`ifdef LUT_MULTIPLIER_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk_seq = 1'b0;
  logic reset_seq;
  always #5 clk_seq = ~clk_seq;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s;
  logic [7:0]  a_s;
  logic [3:0]  b_s;
  logic [11:0] result_s;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [11:0] sb_s[$];
  lut_multiplier_seq dut (
    .clk_seq(clk_seq), .reset_seq(reset_seq), .in_valid_seq(in_valid), .in_ready_seq(in_ready),
    .source_a_seq(a), .source_b_seq(b), .out_valid_seq(out_valid), .out_ready_seq(out_ready),
    .result_seq(result), .busy_seq(busy)
  );
  lut_multiplier_seq #(.WIDTH_A(8), .WIDTH_B(4)) dut_s (
    .clk_seq(clk_seq), .reset_seq(reset_seq), .in_valid_seq(in_valid_s), .in_ready_seq(in_ready_s),
    .source_a_seq(a_s), .source_b_seq(b_s), .out_valid_seq(out_valid_s), .out_ready_seq(out_ready_s),
    .result_seq(result_s), .busy_seq(busy_s)
  );
  function automatic int exp_lat(logic [31:0] bv, int k);
    if (EARLY)
      for (int s = 1; s <= k; s++) if ((bv >> (2 * s)) == 32'd0) return s;
    return k;
  endfunction
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, output int lat, output bit to);
    int w = 0;
    lat = 0;
    while (!in_ready && w < 100) begin @(posedge clk_seq); #1; w++; end
    in_valid = 1'b1; a = av; b = bv;
    sb_q.push_back(64'(av) * 64'(bv));
    @(posedge clk_seq); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin @(posedge clk_seq); #1; lat++; end
    to = !out_valid;
  endtask
  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk_seq); #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    reset_seq = 1'b1;
    repeat (2) @(posedge clk_seq);
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin errors++; $display("FAIL reset_flags: got %b want 100", {in_ready, out_valid, busy}); end
    checks++;
    if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++;
    if ({in_ready_s, out_valid_s, busy_s, result_s} !== {3'b100, 12'd0}) begin errors++; $display("FAIL reset_small: got %b/%h want 100/000", {in_ready_s, out_valid_s, busy_s}, result_s); end
    reset_seq = 1'b0;
    @(posedge clk_seq); #1;
  endtask
  task automatic test_basic();
    int lat; bit to; logic [63:0] e;
    run_op(32'h7, 32'h6, lat, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: got no out_valid want out_valid"); end
    checks++;
    if (lat != exp_lat(32'h6, 16)) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, exp_lat(32'h6, 16)); end
    e = sb_q.pop_front();
    checks++;
    if (result !== e || result !== 64'h2A) begin errors++; $display("FAIL basic_result: got %h want %h", result, e); end
    finish_op();
    checks++;
    if (in_ready !== 1'b1 || result !== 64'h2A) begin errors++; $display("FAIL basic_idle_hold: got ready=%b res=%h want 1/2a", in_ready, result); end
  endtask
  task automatic test_max();
    int lat; bit to; logic [63:0] e;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || result !== e || result !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL max_result: got %h want %h", result, e); end
    checks++;
    if (lat != 16) begin errors++; $display("FAIL max_latency: got %0d want 16", lat); end
    finish_op();
  endtask
  task automatic test_latency();
    logic [31:0] bl [6] = '{32'h0, 32'h3, 32'h100, 32'h6, 32'h8000_0000, 32'h0001_0000};
    int lat; bit to; logic [63:0] e;
    foreach (bl[i]) begin
      run_op(32'h1234_5678, bl[i], lat, to);
      e = sb_q.pop_front();
      checks++;
      if (to || lat != exp_lat(bl[i], 16)) begin errors++; $display("FAIL latency_b%h: got %0d want %0d", bl[i], lat, exp_lat(bl[i], 16)); end
      checks++;
      if (result !== e) begin errors++; $display("FAIL latency_result_b%h: got %h want %h", bl[i], result, e); end
      finish_op();
    end
  endtask
  task automatic test_hold_done();
    int lat; bit to; logic [63:0] e;
    run_op(32'd3, 32'd4, lat, to);
    e = sb_q.pop_front();
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd9; b = 32'd11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_seq); #1;
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b100 || result !== e) begin errors++; $display("FAIL hold_done_c%0d: got %b/%h want 100/%h", i, {out_valid, in_ready, busy}, result, e); end
    end
    out_ready = 1'b1;
    @(posedge clk_seq); #1;
    out_ready = 1'b0;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin errors++; $display("FAIL hold_no_reaccept: got %b want 100", {in_ready, busy, out_valid}); end
    sb_q.push_back(64'd99);
    @(posedge clk_seq); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL hold_accept_after_idle: got busy=%b want 1", busy); end
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk_seq); #1; lat++; end
    e = sb_q.pop_front();
    checks++;
    if (!out_valid || result !== e) begin errors++; $display("FAIL hold_next_result: got %h want %h", result, e); end
    finish_op();
  endtask
  task automatic test_reset_mid();
    int lat, seen; bit to; logic [63:0] e;
    in_valid = 1'b1; a = 32'hFFFF; b = 32'hFFFF_FFFF;
    @(posedge clk_seq); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk_seq);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid_busy: got %b want 1", busy); end
    #2 reset_seq = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || result !== 64'd0) begin errors++; $display("FAIL reset_mid_immediate: got %b/%h want 100/0", {in_ready, out_valid, busy}, result); end
    @(posedge clk_seq); #1;
    reset_seq = 1'b0;
    seen = 0;
    repeat (20) begin @(posedge clk_seq); #1; if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_discard: got %0d valid cycles want 0", seen); end
    run_op(32'd3, 32'd5, lat, to);
    e = sb_q.pop_front();
    checks++;
    if (to || result !== e || result !== 64'd15) begin errors++; $display("FAIL reset_mid_next: got %h want %h", result, e); end
    finish_op();
  endtask
  task automatic test_random();
    fork
      begin
        int done_cnt = 0, cyc = 0;
        logic [63:0] e;
        while (done_cnt < 2000 && cyc < 80000) begin
          in_valid  = $urandom_range(0, 3) != 0;
          a         = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFF : $urandom;
          b         = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 1023)) : $urandom;
          out_ready = $urandom_range(0, 3) != 0;
          if (in_valid && in_ready) sb_q.push_back(64'(a) * 64'(b));
          if (out_valid && out_ready) begin
            e = sb_q.size() != 0 ? sb_q.pop_front() : ~result;
            checks++;
            if (result !== e) begin errors++; $display("FAIL random_big_%0d: got %h want %h", done_cnt, result, e); end
            done_cnt++;
          end
          @(posedge clk_seq); #1;
          cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (done_cnt < 2000) begin errors++; $display("FAIL random_big_timeout: got %0d results want 2000", done_cnt); end
      end
      begin
        int done_cnt = 0, cyc = 0;
        logic [11:0] e;
        while (done_cnt < 10000 && cyc < 80000) begin
          in_valid_s  = $urandom_range(0, 3) != 0;
          a_s         = 8'($urandom);
          b_s         = 4'($urandom);
          out_ready_s = $urandom_range(0, 3) != 0;
          if (in_valid_s && in_ready_s) sb_s.push_back(12'(a_s) * 12'(b_s));
          if (out_valid_s && out_ready_s) begin
            e = sb_s.size() != 0 ? sb_s.pop_front() : ~result_s;
            checks++;
            if (result_s !== e) begin errors++; $display("FAIL random_small_%0d: got %h want %h", done_cnt, result_s, e); end
            done_cnt++;
          end
          @(posedge clk_seq); #1;
          cyc++;
        end
        in_valid_s = 1'b0; out_ready_s = 1'b0;
        checks++;
        if (done_cnt < 10000) begin errors++; $display("FAIL random_small_timeout: got %0d results want 10000", done_cnt); end
      end
    join
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    reset_seq = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid_s = 1'b0; out_ready_s = 1'b0; a_s = '0; b_s = '0;
    test_reset();
    test_basic();
    test_max();
    test_latency();
    test_hold_done();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
